ip_codma_bus_responder: RTL and testbench

// - Bus-side responder (slave end) of the codma BUS_IF protocol; pairs with the codma read/write machines.
// - Holds a DEPTH x 64-bit memory; grants requests, returns read beats, absorbs write beats, flags errors.
// - Used as the system-memory target in the codma subsystem bench and as the on-chip scratch target.

---
 rtl/ip_codma_machine_states_pkg.sv | 32 +++
 rtl/ip_codma_bus_responder_if.sv | 36 +++
 rtl/ip_codma_resp_mem.sv | 34 +++
 rtl/ip_codma_bus_responder.sv | 208 ++++++++++++++++++++
 tb/tb_ip_codma_bus_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_codma_machine_states_pkg.sv
// ---------------------------------------------------------------------------
// ip_codma_machine_states_pkg
// Shared types and constants for the codma bus machines.
//   resp_state_t   : responder FSM states
//   SIZE_8B/16B/32B: size_i encodings understood by the bus
//   size_to_beats  : number of 64-bit beats for a size code, 0 when illegal
// ---------------------------------------------------------------------------
package ip_codma_machine_states_pkg;

  typedef enum logic [2:0] {
    RESP_IDLE  = 3'd0,
    RESP_DELAY = 3'd1,
    RESP_GRANT = 3'd2,
    RESP_READ  = 3'd3,
    RESP_WRITE = 3'd4,
    RESP_ERROR = 3'd5
  } resp_state_t;

  localparam logic [3:0] SIZE_8B  = 4'd3;
  localparam logic [3:0] SIZE_16B = 4'd8;
  localparam logic [3:0] SIZE_32B = 4'd9;

  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    case (size)
      SIZE_8B:  return 3'd1;
      SIZE_16B: return 3'd2;
      SIZE_32B: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_bus_responder_if.sv
// ---------------------------------------------------------------------------
// ip_codma_bus_responder_if
// codma BUS_IF signal bundle between a codma master and a bus responder.
//   req         master request, held for the whole transfer
//   addr/size   byte address and size code, sampled with req in responder IDLE
//   write       1 = write transfer, 0 = read transfer
//   write_valid / write_data   write beat from the master
//   grant       one-cycle grant pulse from the responder
//   read_valid / read_data     read beat from the responder
//   error       one-cycle error pulse for an illegal request
//   busy        responder is not idle
// Modports: master (drives request side), slave (drives response side).
// ---------------------------------------------------------------------------
interface ip_codma_bus_responder_if;
  logic        req;
  logic [31:0] addr;
  logic [3:0]  size;
  logic        write;
  logic        write_valid;
  logic [63:0] write_data;
  logic        grant;
  logic        read_valid;
  logic [63:0] read_data;
  logic        error;
  logic        busy;

  modport master (
    output req, addr, size, write, write_valid, write_data,
    input  grant, read_valid, read_data, error, busy
  );

  modport slave (
    input  req, addr, size, write, write_valid, write_data,
    output grant, read_valid, read_data, error, busy
  );
endinterface

// File: rtl/ip_codma_resp_mem.sv
// ---------------------------------------------------------------------------
// ip_codma_resp_mem
// DEPTH x 64-bit storage for the bus responder. One synchronous write port,
// one combinational read port, contents are not reset.
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
// ---------------------------------------------------------------------------
module ip_codma_resp_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ip_codma_bus_responder.sv
// ---------------------------------------------------------------------------
// ip_codma_bus_responder
// Slave end of the codma BUS_IF protocol backed by a DEPTH x 64-bit memory.
// Accepts a request in IDLE, checks it, optionally waits GRANT_DELAY cycles,
// pulses grant, then streams read beats or absorbs write beats.
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   bus        ip_codma_bus_responder_if.slave (request in, response out)
// Parameters: DEPTH (words), GRANT_DELAY (0..15), WAIT_CYCLES (1..7).
// Build option: define CODMA_RESP_WAIT_EN to insert WAIT_CYCLES gap cycles
// after every non-final beat; without it beats run back to back and no gap
// counter exists.
// ---------------------------------------------------------------------------
module ip_codma_bus_responder
  import ip_codma_machine_states_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int GRANT_DELAY = 1,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  ip_codma_bus_responder_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] DLY_LAST = 4'(GRANT_DELAY - 1);

  if (DEPTH < 4 || GRANT_DELAY < 0 || GRANT_DELAY > 15 ||
      WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_param_check
    $error("ip_codma_bus_responder: parameter out of range");
  end

  resp_state_t   state_q, state_d;
  logic [AW-1:0] base_q,  base_d;
  logic [1:0]    last_q,  last_d;
  logic [1:0]    beat_q,  beat_d;
  logic          write_q, write_d;
  logic [3:0]    dly_q,   dly_d;
  logic          gap_open;

`ifdef CODMA_RESP_WAIT_EN
  localparam logic [2:0] GAP_RELOAD = 3'(WAIT_CYCLES);
  logic [2:0] gap_q, gap_d;
  assign gap_open = (gap_q == 3'd0);
`else
  assign gap_open = 1'b1;
`endif

  // Request checks, evaluated on the live bus while IDLE.
  // The end-of-range test is done in 32 bits so a high address cannot wrap.
  logic [2:0]  req_beats;
  logic [1:0]  req_last;
  logic [31:0] req_word;
  logic [31:0] req_end;
  logic        req_legal;

  assign req_beats = size_to_beats(bus.size);
  assign req_last  = 2'(req_beats - 3'd1);
  assign req_word  = {3'b000, bus.addr[31:3]};
  assign req_end   = req_word + {29'd0, req_beats};
  assign req_legal = (req_beats != 3'd0) && (bus.addr[2:0] == 3'b000) &&
                     (req_end <= 32'(DEPTH));

  // Beat strobes are gated by req so an abort suppresses the beat at once.
  logic rd_fire;
  logic wr_fire;

  assign rd_fire = (state_q == RESP_READ)  && bus.req && gap_open;
  assign wr_fire = (state_q == RESP_WRITE) && bus.req && gap_open &&
                   bus.write_valid;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    last_d  = last_q;
    beat_d  = beat_q;
    write_d = write_q;
    dly_d   = dly_q;
`ifdef CODMA_RESP_WAIT_EN
    gap_d   = gap_open ? gap_q : gap_q - 3'd1;
`endif

    case (state_q)
      RESP_IDLE: begin
        if (bus.req) begin
          base_d  = req_word[AW-1:0];
          last_d  = req_last;
          write_d = bus.write;
          beat_d  = 2'd0;
          dly_d   = 4'd0;
`ifdef CODMA_RESP_WAIT_EN
          gap_d   = 3'd0;
`endif
          if (!req_legal) begin
            state_d = RESP_ERROR;
          end else if (GRANT_DELAY > 0) begin
            state_d = RESP_DELAY;
          end else begin
            state_d = RESP_GRANT;
          end
        end
      end

      RESP_DELAY: begin
        if (!bus.req) begin
          state_d = RESP_IDLE;
        end else if (dly_q == DLY_LAST) begin
          state_d = RESP_GRANT;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end

      RESP_GRANT: begin
        if (!bus.req) begin
          state_d = RESP_IDLE;
        end else begin
          state_d = write_q ? RESP_WRITE : RESP_READ;
        end
      end

      RESP_READ: begin
        if (!bus.req) begin
          state_d = RESP_IDLE;
        end else if (rd_fire) begin
          if (beat_q == last_q) begin
            state_d = RESP_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
`ifdef CODMA_RESP_WAIT_EN
            gap_d  = GAP_RELOAD;
`endif
          end
        end
      end

      RESP_WRITE: begin
        if (!bus.req) begin
          state_d = RESP_IDLE;
        end else if (wr_fire) begin
          if (beat_q == last_q) begin
            state_d = RESP_IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
`ifdef CODMA_RESP_WAIT_EN
            gap_d  = GAP_RELOAD;
`endif
          end
        end
      end

      RESP_ERROR: state_d = RESP_IDLE;

      default:    state_d = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RESP_IDLE;
      base_q  <= '0;
      last_q  <= 2'd0;
      beat_q  <= 2'd0;
      write_q <= 1'b0;
      dly_q   <= 4'd0;
`ifdef CODMA_RESP_WAIT_EN
      gap_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      write_q <= write_d;
      dly_q   <= dly_d;
`ifdef CODMA_RESP_WAIT_EN
      gap_q   <= gap_d;
`endif
    end
  end

  // Range check already guarantees base + beat stays inside the array.
  logic [AW-1:0] mem_idx;
  logic [63:0]   mem_rdata;

  assign mem_idx = base_q + AW'(beat_q);

  ip_codma_resp_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_fire),
    .waddr_i (mem_idx),
    .wdata_i (bus.write_data),
    .raddr_i (mem_idx),
    .rdata_o (mem_rdata)
  );

  // Outputs decode from registered state so async reset clears them at once.
  assign bus.grant      = (state_q == RESP_GRANT) && bus.req;
  assign bus.read_valid = rd_fire;
  assign bus.read_data  = rd_fire ? mem_rdata : 64'd0;
  assign bus.error      = (state_q == RESP_ERROR);
  assign bus.busy       = (state_q != RESP_IDLE);

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
module tb_ip_codma_bus_responder;
  import ip_codma_machine_states_pkg::*;

  localparam int DEPTH = 256;
  localparam int GD    = 1;
  localparam int WC    = 2;
`ifdef CODMA_RESP_WAIT_EN
  localparam int GAP = WC;
`else
  localparam int GAP = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference memory: what each word must hold according to accepted beats.
  logic [63:0] mdl [DEPTH];

  ip_codma_bus_responder_if bus();

  ip_codma_bus_responder #(
    .DEPTH       (DEPTH),
    .GRANT_DELAY (GD),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Cycle (counted from grant) at which read beat k must appear.
  function automatic int beat_off(input int k);
    return 1 + k * (GAP + 1);
  endfunction

  function automatic logic [3:0] size_code(input int nb);
    if (nb == 1) return SIZE_8B;
    if (nb == 2) return SIZE_16B;
    return SIZE_32B;
  endfunction

  // ---------------- bus drivers (observe only, no checking) ----------------
  task automatic do_req(input logic [31:0] a, input logic [3:0] sz, input logic wr,
                        output int g, output int e);
    bus.req = 1'b1; bus.addr = a; bus.size = sz; bus.write = wr;
    g = -1; e = -1;
    for (int c = 1; c <= 40 && g < 0 && e < 0; c++) begin
      @(negedge clk);
      if (bus.grant) g = c;
      if (bus.error) e = c;
    end
  endtask

  task automatic drv_write(input int nb, input logic [63:0] wd [4], input int st [4],
                           output int cyc, output logic bok, output logic bend);
    cyc = 0; bok = 1'b1;
    bus.write_valid = 1'b1;                  // grant cycle: must be ignored
    bus.write_data = {$urandom, $urandom};
    @(negedge clk); cyc++;
    for (int k = 0; k < nb; k++) begin
      for (int s = 0; s < st[k]; s++) begin
        bok = bok & bus.busy;
        bus.write_valid = 1'b0;
        @(negedge clk); cyc++;
      end
      bok = bok & bus.busy;
      bus.write_valid = 1'b1; bus.write_data = wd[k];
      @(negedge clk); cyc++;
      if (k < nb - 1) begin
        for (int s = 0; s < GAP; s++) begin
          bok = bok & bus.busy;
          bus.write_valid = 1'b1; bus.write_data = {$urandom, $urandom};
          @(negedge clk); cyc++;
        end
      end
    end
    bus.write_valid = 1'b0;
    bend = bus.busy;
    bus.req = 1'b0;
  endtask

  task automatic drv_read(input int nb, input int abort_after, input bit keep_req,
                          output logic [63:0] rd [4], output int off [4],
                          output int got, output int idle, output int extra);
    got = 0; idle = -1; extra = 0;
    for (int k = 0; k < 4; k++) begin rd[k] = '0; off[k] = -1; end
    for (int c = 1; c <= nb * (GAP + 1) + 8 && idle < 0; c++) begin
      @(negedge clk);
      if (bus.read_valid) begin
        if (got < 4) begin rd[got] = bus.read_data; off[got] = c; end
        got++;
      end
      if (!bus.busy) begin
        idle = c;
        if (!keep_req) bus.req = 1'b0;
      end else if (abort_after > 0 && got >= abort_after) begin
        bus.req = 1'b0;
      end
    end
    if (!keep_req) begin
      bus.req = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (bus.read_valid || bus.grant || bus.busy || bus.error) extra++;
      end
    end
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    bus.req = 1'b0; bus.addr = '0; bus.size = '0; bus.write = 1'b0;
    bus.write_valid = 1'b0; bus.write_data = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%b exp=0", bus.grant); end
    total++; if (bus.read_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.read_valid); end
    total++; if (bus.read_data !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.read_data); end
    total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", bus.error); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_preload();
    int g, e, cyc; logic bok, bend; logic [63:0] wd [4]; int st [4];
    for (int i = 0; i < DEPTH / 4; i++) begin
      for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; st[k] = 0; end
      do_req(32'(i * 32), SIZE_32B, 1'b1, g, e);
      total++; if (g !== 1 + GD) begin bad++; $display("FAIL preload_grant[%0d] got=%0d exp=%0d", i, g, 1 + GD); end
      drv_write(4, wd, st, cyc, bok, bend);
      total++; if (bend !== 1'b0 || cyc !== 5 + 3 * GAP) begin
        bad++; $display("FAIL preload_end[%0d] busy=%b cyc=%0d exp_cyc=%0d", i, bend, cyc, 5 + 3 * GAP);
      end
      for (int k = 0; k < 4; k++) mdl[i * 4 + k] = wd[k];
    end
  endtask

  task automatic test_read_32b();
    int g, e, cyc, got, idle, extra; logic bok, bend;
    logic [63:0] wd [4]; int st [4]; logic [63:0] rd [4]; int off [4];
    for (int k = 0; k < 4; k++) begin wd[k] = {32'hA0A0_0000 + 32'(k), $urandom}; st[k] = 0; end
    do_req(32'h40, SIZE_32B, 1'b1, g, e);
    drv_write(4, wd, st, cyc, bok, bend);
    for (int k = 0; k < 4; k++) mdl[8 + k] = wd[k];
    do_req(32'h40, SIZE_32B, 1'b0, g, e);
    total++; if (g !== 1 + GD) begin bad++; $display("FAIL rd32_grant got=%0d exp=%0d", g, 1 + GD); end
    drv_read(4, 0, 1'b0, rd, off, got, idle, extra);
    for (int k = 0; k < 4; k++) begin
      total++; if (rd[k] !== mdl[8 + k]) begin bad++; $display("FAIL rd32_data[%0d] got=%h exp=%h", k, rd[k], mdl[8 + k]); end
      total++; if (off[k] !== beat_off(k)) begin bad++; $display("FAIL rd32_timing[%0d] got=%0d exp=%0d", k, off[k], beat_off(k)); end
    end
    total++; if (got !== 4 || extra !== 0) begin bad++; $display("FAIL rd32_count got=%0d extra=%0d exp=4/0", got, extra); end
    total++; if (idle !== beat_off(3) + 1) begin bad++; $display("FAIL rd32_idle got=%0d exp=%0d", idle, beat_off(3) + 1); end
  endtask

  task automatic test_write_stall();
    int g, e, cyc, got, idle, extra; logic bok, bend;
    logic [63:0] wd [4]; int st [4]; logic [63:0] rd [4]; int off [4];
    wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; wd[2] = '0; wd[3] = '0;
    st[0] = 0; st[1] = 3; st[2] = 0; st[3] = 0;
    do_req(32'h10, SIZE_16B, 1'b1, g, e);
    total++; if (g !== 1 + GD) begin bad++; $display("FAIL wr16_grant got=%0d exp=%0d", g, 1 + GD); end
    drv_write(2, wd, st, cyc, bok, bend);
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL wr16_busy_in_stall got=%b exp=1", bok); end
    total++; if (bend !== 1'b0 || cyc !== 6 + GAP) begin
      bad++; $display("FAIL wr16_end busy=%b cyc=%0d exp_cyc=%0d", bend, cyc, 6 + GAP);
    end
    mdl[2] = wd[0]; mdl[3] = wd[1];
    do_req(32'h10, SIZE_16B, 1'b0, g, e);
    drv_read(2, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== wd[0]) begin bad++; $display("FAIL wr16_rb0 got=%h exp=%h", rd[0], wd[0]); end
    total++; if (rd[1] !== wd[1]) begin bad++; $display("FAIL wr16_rb1 got=%h exp=%h", rd[1], wd[1]); end
    do_req(32'h20, SIZE_8B, 1'b0, g, e);
    drv_read(1, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== mdl[4] || got !== 1) begin bad++; $display("FAIL wr16_neighbour got=%h exp=%h", rd[0], mdl[4]); end
  endtask

  task automatic test_errors();
    int g, e, act, got, idle, extra; logic [63:0] rd [4]; int off [4];
    logic [31:0] ea [5]; logic [3:0] es [5];
    ea[0] = 32'h0;               es[0] = 4'd5;
    ea[1] = 32'h4;               es[1] = SIZE_8B;
    ea[2] = 32'((DEPTH - 2) * 8); es[2] = SIZE_32B;
    ea[3] = 32'((DEPTH - 1) * 8); es[3] = SIZE_16B;
    ea[4] = 32'hFFFF_FFF8;       es[4] = SIZE_8B;
    for (int i = 0; i < 5; i++) begin
      do_req(ea[i], es[i], 1'(i), g, e);
      total++; if (e !== 1 || g !== -1) begin bad++; $display("FAIL err[%0d] err_cyc=%0d grant_cyc=%0d exp=1/-1", i, e, g); end
      bus.req = 1'b0;
      act = 0;
      repeat (3) begin
        @(negedge clk);
        if (bus.error || bus.grant || bus.busy || bus.read_valid) act++;
      end
      total++; if (act !== 0) begin bad++; $display("FAIL err_pulse[%0d] extra_active=%0d exp=0", i, act); end
    end
    do_req(32'((DEPTH - 1) * 8), SIZE_8B, 1'b0, g, e);
    total++; if (g !== 1 + GD || e !== -1) begin bad++; $display("FAIL last_word_grant got=%0d err=%0d exp=%0d", g, e, 1 + GD); end
    drv_read(1, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== mdl[DEPTH - 1] || got !== 1) begin bad++; $display("FAIL last_word_data got=%h exp=%h", rd[0], mdl[DEPTH - 1]); end
    do_req(32'((DEPTH - 2) * 8), SIZE_16B, 1'b0, g, e);
    drv_read(2, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== mdl[DEPTH - 2] || rd[1] !== mdl[DEPTH - 1]) begin
      bad++; $display("FAIL err_mem_kept got=%h/%h exp=%h/%h", rd[0], rd[1], mdl[DEPTH - 2], mdl[DEPTH - 1]);
    end
    do_req(32'h0, SIZE_8B, 1'b0, g, e);
    drv_read(1, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== mdl[0]) begin bad++; $display("FAIL err_mem0_kept got=%h exp=%h", rd[0], mdl[0]); end
  endtask

  task automatic test_abort_read();
    int g, e, got, idle, extra; logic [63:0] rd [4]; int off [4];
    do_req(32'h100, SIZE_32B, 1'b0, g, e);
    drv_read(4, 1, 1'b0, rd, off, got, idle, extra);
    total++; if (got !== 1) begin bad++; $display("FAIL abort_beats got=%0d exp=1", got); end
    total++; if (rd[0] !== mdl[32]) begin bad++; $display("FAIL abort_data got=%h exp=%h", rd[0], mdl[32]); end
    total++; if (idle !== beat_off(0) + 1 || extra !== 0) begin
      bad++; $display("FAIL abort_idle got=%0d extra=%0d exp=%0d/0", idle, extra, beat_off(0) + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int g, e, got, idle, extra; logic [63:0] d0, d1; logic [63:0] rd [4]; int off [4];
    d0 = {$urandom, $urandom}; d1 = ~mdl[17];
    do_req(32'h80, SIZE_32B, 1'b1, g, e);
    total++; if (g !== 1 + GD) begin bad++; $display("FAIL rstw_grant got=%0d exp=%0d", g, 1 + GD); end
    bus.write_valid = 1'b0;
    @(negedge clk);
    bus.write_valid = 1'b1; bus.write_data = d0;
    @(negedge clk);
    bus.write_valid = 1'b0;
    repeat (GAP) @(negedge clk);
    bus.write_valid = 1'b1; bus.write_data = d1;
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstw_mid_busy got=%b exp=1", bus.busy); end
    reset_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstw_busy got=%b exp=0", bus.busy); end
    total++; if ({bus.grant, bus.read_valid, bus.error, bus.read_data} !== 67'd0) begin
      bad++; $display("FAIL rstw_outputs got=%b%b%b_%h exp=0", bus.grant, bus.read_valid, bus.error, bus.read_data);
    end
    @(negedge clk);
    bus.req = 1'b0; bus.write_valid = 1'b0; reset_n = 1'b1;
    mdl[16] = d0;
    @(negedge clk);
    do_req(32'h80, SIZE_32B, 1'b0, g, e);
    drv_read(4, 0, 1'b0, rd, off, got, idle, extra);
    for (int k = 0; k < 4; k++) begin
      total++; if (rd[k] !== mdl[16 + k]) begin bad++; $display("FAIL rstw_mem[%0d] got=%h exp=%h", k, rd[k], mdl[16 + k]); end
    end
  endtask

  task automatic test_back_to_back();
    int g1, g2, e, got, idle, extra; logic [63:0] rd [4]; int off [4];
    do_req(32'h200, SIZE_32B, 1'b0, g1, e);
    drv_read(4, 0, 1'b1, rd, off, got, idle, extra);
    total++; if (idle !== beat_off(3) + 1 || got !== 4) begin
      bad++; $display("FAIL b2b_first idle=%0d got=%0d exp=%0d/4", idle, got, beat_off(3) + 1);
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (rd[k] !== mdl[64 + k]) begin bad++; $display("FAIL b2b_d1[%0d] got=%h exp=%h", k, rd[k], mdl[64 + k]); end
    end
    do_req(32'h300, SIZE_16B, 1'b0, g2, e);
    total++; if (g2 < 0 || idle + g2 - off[3] !== 2 + GD) begin
      bad++; $display("FAIL b2b_gap got=%0d exp=%0d", idle + g2 - off[3], 2 + GD);
    end
    drv_read(2, 0, 1'b0, rd, off, got, idle, extra);
    total++; if (rd[0] !== mdl[96] || rd[1] !== mdl[97] || got !== 2) begin
      bad++; $display("FAIL b2b_d2 got=%h/%h exp=%h/%h", rd[0], rd[1], mdl[96], mdl[97]);
    end
  endtask

  task automatic test_random();
    int g, e, cyc, got, idle, extra, nb, w, r, ssum; logic bok, bend;
    logic [63:0] wd [4]; int st [4]; logic [63:0] rd [4]; int off [4];
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 5));
      if (r == 0) begin
        w = int'($urandom_range(0, 2));
        if (w == 0) do_req(32'h8, 4'(4 + $urandom_range(0, 3)), 1'b1, g, e);
        else if (w == 1) do_req(32'h18 | 32'($urandom_range(1, 7)), SIZE_16B, 1'b0, g, e);
        else do_req(32'((DEPTH - 3) * 8), SIZE_32B, 1'b1, g, e);
        total++; if (e !== 1 || g !== -1) begin bad++; $display("FAIL rnd_err[%0d] err=%0d grant=%0d", it, e, g); end
        bus.req = 1'b0;
        @(negedge clk);
      end else begin
        nb = 1 << $urandom_range(0, 2);
        w = int'($urandom_range(0, DEPTH - nb));
        if (r >= 3) begin
          ssum = 0;
          for (int k = 0; k < 4; k++) begin
            wd[k] = {$urandom, $urandom}; st[k] = int'($urandom_range(0, 2)); if (k < nb) ssum += st[k];
          end
          do_req(32'(w * 8), size_code(nb), 1'b1, g, e);
          total++; if (g !== 1 + GD) begin bad++; $display("FAIL rnd_wgrant[%0d] got=%0d exp=%0d", it, g, 1 + GD); end
          drv_write(nb, wd, st, cyc, bok, bend);
          total++; if (bok !== 1'b1 || bend !== 1'b0 || cyc !== 1 + ssum + nb + GAP * (nb - 1)) begin
            bad++; $display("FAIL rnd_wend[%0d] bok=%b busy=%b cyc=%0d exp=%0d", it, bok, bend, cyc, 1 + ssum + nb + GAP * (nb - 1));
          end
          for (int k = 0; k < nb; k++) mdl[w + k] = wd[k];
        end else begin
          do_req(32'(w * 8), size_code(nb), 1'b0, g, e);
          total++; if (g !== 1 + GD) begin bad++; $display("FAIL rnd_rgrant[%0d] got=%0d exp=%0d", it, g, 1 + GD); end
          drv_read(nb, 0, 1'b0, rd, off, got, idle, extra);
          total++; if (got !== nb || extra !== 0) begin bad++; $display("FAIL rnd_rcount[%0d] got=%0d extra=%0d exp=%0d", it, got, extra, nb); end
          for (int k = 0; k < nb; k++) begin
            total++; if (rd[k] !== mdl[w + k] || off[k] !== beat_off(k)) begin
              bad++; $display("FAIL rnd_rdata[%0d.%0d] got=%h@%0d exp=%h@%0d", it, k, rd[k], off[k], mdl[w + k], beat_off(k));
            end
          end
        end
      end
    end
  endtask

  task automatic test_sweep();
    int g, e, got, idle, extra; logic [63:0] rd [4]; int off [4];
    for (int i = 0; i < DEPTH / 4; i++) begin
      do_req(32'(i * 32), SIZE_32B, 1'b0, g, e);
      drv_read(4, 0, 1'b0, rd, off, got, idle, extra);
      for (int k = 0; k < 4; k++) begin
        total++; if (rd[k] !== mdl[i * 4 + k]) begin
          bad++; $display("FAIL sweep[%0d] got=%h exp=%h", i * 4 + k, rd[k], mdl[i * 4 + k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_32b();
    test_write_stall();
    test_errors();
    test_abort_read();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
